// File: rtl/vga_capture.sv
// VGA pixel-stream receiver: recovers coordinates, checks frame geometry, writes
// active pixels to a frame store. Define VGA_CAPTURE_GRAY_EN to store luma instead of red.
module vga_capture #(
  parameter int HACTIVE = 640,
  parameter int VACTIVE = 480,
  parameter int AW      = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_clk_in,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank_n,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  input  logic          chipselect,
  input  logic          read,
  input  logic [2:0]    address,
  output logic [7:0]    readdata,
  output logic [AW-1:0] address_write,
  output logic [7:0]    data_in,
  output logic          write_ena,
  output logic          locked
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]    H_L  = 10'(HACTIVE);
  localparam logic [9:0]    V_L  = 10'(VACTIVE);
  localparam logic [AW-1:0] H_AW = AW'(HACTIVE);

  logic          s1_clk_q, s1_vs_q, s1_blank_q;
  logic [7:0]    s1_r_q;
  logic          s2_clk_q, s2_vs_q, s2_blank_q;
  logic [9:0]    x_q, y_q, last_len_q, last_lines_q;
  logic [7:0]    frame_cnt_q, err_cnt_q, rdata_q, data_q;
  logic          bad_q, locked_q, we_q;
  logic [AW-1:0] addr_q;
  state_t        state_q;

  logic          pix, vsf, eol, line_bad, frame_good, wr_ok;
  logic [7:0]    pix_data, reg_d;
  logic          unused_hs;

  assign unused_hs = vga_hs;

`ifdef VGA_CAPTURE_GRAY_EN
  logic [7:0] s1_g_q, s1_b_q;
  logic [9:0] gray_sum;
  assign gray_sum = {2'b00, s1_r_q} + {1'b0, s1_g_q, 1'b0} + {2'b00, s1_b_q};
  assign pix_data = gray_sum[9:2];
`else
  logic [15:0] unused_gb;
  assign unused_gb = {vga_g, vga_b};
  assign pix_data  = s1_r_q;
`endif

  // Events are only meaningful on the pixel-clock rising edge seen through S1/S2.
  assign pix        = s1_clk_q & ~s2_clk_q;
  assign vsf        = pix & s2_vs_q & ~s1_vs_q;
  assign eol        = pix & s2_blank_q & ~s1_blank_q;
  assign line_bad   = eol & (x_q != H_L);
  assign frame_good = (y_q == V_L) & ~bad_q & ~line_bad;
  assign wr_ok      = (state_q == LOCKED) & pix & s1_blank_q & (x_q < H_L) & (y_q < V_L);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    reg_d = 8'h00;
    case (address)
      3'd0: reg_d = {5'b0, state_q, locked_q};
      3'd1: reg_d = frame_cnt_q;
      3'd2: reg_d = err_cnt_q;
      3'd3: reg_d = {6'b0, last_len_q[9:8]};
      3'd4: reg_d = last_len_q[7:0];
      3'd5: reg_d = {6'b0, last_lines_q[9:8]};
      3'd6: reg_d = last_lines_q[7:0];
      default: reg_d = 8'h00;
    endcase
  end

  // NOTE: reset is synchronous (sampled only on clk), and all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_clk_q <= 1'b0; s1_vs_q <= 1'b0; s1_blank_q <= 1'b0; s1_r_q <= 8'h00;
      s2_clk_q <= 1'b0; s2_vs_q <= 1'b0; s2_blank_q <= 1'b0;
`ifdef VGA_CAPTURE_GRAY_EN
      s1_g_q <= 8'h00; s1_b_q <= 8'h00;
`endif
      x_q <= '0; y_q <= '0; last_len_q <= '0; last_lines_q <= '0;
      frame_cnt_q <= '0; err_cnt_q <= '0; bad_q <= 1'b0;
      state_q <= SEARCH; locked_q <= 1'b0;
      we_q <= 1'b0; addr_q <= '0; data_q <= '0; rdata_q <= '0;
    end else begin
      s1_clk_q   <= vga_clk_in;
      s1_vs_q    <= vga_vs;
      s1_blank_q <= vga_blank_n;
      s1_r_q     <= vga_r;
`ifdef VGA_CAPTURE_GRAY_EN
      s1_g_q     <= vga_g;
      s1_b_q     <= vga_b;
`endif
      s2_clk_q   <= s1_clk_q;
      s2_vs_q    <= s1_vs_q;
      s2_blank_q <= s1_blank_q;

      we_q <= wr_ok;
      if (wr_ok) begin
        addr_q <= AW'(y_q) * H_AW + AW'(x_q);
        data_q <= pix_data;
      end

      if (pix) begin
        if (eol) begin
          last_len_q <= x_q;
          x_q        <= '0;
          y_q        <= y_q + 10'd1;
        end else if (s1_blank_q) begin
          x_q <= x_q + 10'd1;
        end
        if (vsf) begin
          last_lines_q <= y_q;
          y_q          <= '0;
          frame_cnt_q  <= frame_cnt_q + 8'd1;
          bad_q        <= 1'b0;
        end else if (line_bad) begin
          bad_q <= 1'b1;
        end
      end

      case (state_q)
        SEARCH: if (vsf) state_q <= ALIGN;
        ALIGN: if (vsf && frame_good) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end
        LOCKED: if (line_bad || (vsf && !frame_good)) begin
          // A bad line coinciding with vsf is still a single error.
          state_q  <= SEARCH;
          locked_q <= 1'b0;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase

      if (chipselect && read) rdata_q <= reg_d;
    end
  end

  assign readdata      = rdata_q;
  assign address_write = addr_q;
  assign data_in       = data_q;
  assign write_ena     = we_q;
  assign locked        = locked_q;

endmodule
